// File: rtl/noc_switch_pkg.sv
// Shared types and constants for the NoC switch allocator: per-input path
// state encoding, default port counts and a small modular-increment helper.
package noc_switch_pkg;

  typedef enum logic [1:0] {
    ST_UNROUTED = 2'd0,
    ST_REQUEST  = 2'd1,
    ST_GRANTED  = 2'd2,
    ST_RESERVED = 2'd3
  } port_state_t;

  localparam int DEFAULT_INPUTS  = 5;
  localparam int DEFAULT_OUTPUTS = 5;
  localparam int STATE_WIDTH     = 2;

  function automatic int wrap_inc(input int value, input int modulus);
    return (value + 1 >= modulus) ? 0 : value + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Per-output arbiter: one-hot grant over WIDTH requesters. With SWITCH_ALLOC_RR_EN
// defined it is round-robin with an internal pointer; otherwise lowest index wins.
module rr_arbiter
  import noc_switch_pkg::*;
#(
  parameter int WIDTH = DEFAULT_INPUTS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] req,
  output logic [WIDTH-1:0] grant
);

`ifdef SWITCH_ALLOC_RR_EN
  localparam int PTR_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [PTR_WIDTH-1:0] ptr;
  logic [PTR_WIDTH-1:0] ptr_next;

  // Two passes: first from the pointer upward, then wrap to the low indices.
  always_comb begin
    logic found;
    logic hit;
    found    = 1'b0;
    hit      = 1'b0;
    grant    = {WIDTH{1'b0}};
    ptr_next = ptr;
    for (int i = 0; i < WIDTH; i++) begin
      hit      = req[i] & ~found & (i >= int'(ptr));
      grant[i] = hit;
      found    = found | hit;
      ptr_next = hit ? PTR_WIDTH'(wrap_inc(i, WIDTH)) : ptr_next;
    end
    for (int i = 0; i < WIDTH; i++) begin
      hit      = req[i] & ~found;
      grant[i] = grant[i] | hit;
      found    = found | hit;
      ptr_next = hit ? PTR_WIDTH'(wrap_inc(i, WIDTH)) : ptr_next;
    end
  end

  // Pointer only moves on a grant; otherwise ptr_next equals ptr.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= {PTR_WIDTH{1'b0}};
    end else begin
      ptr <= ptr_next;
    end
  end
`else
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst;

  // Fixed priority: the lowest requesting index wins.
  always_comb begin
    logic found;
    found = 1'b0;
    grant = {WIDTH{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      grant[i] = req[i] & ~found;
      found    = found | req[i];
    end
  end
`endif

endmodule

// File: rtl/switch_allocator_rr.sv
// NoC switch allocator: per-input path FSM plus one arbiter per output.
// Define SWITCH_ALLOC_RR_EN for round-robin arbitration (default: fixed priority).
module switch_allocator_rr
  import noc_switch_pkg::*;
#(
  parameter int INPUTS        = DEFAULT_INPUTS,
  parameter int OUTPUTS       = DEFAULT_OUTPUTS,
  parameter int REQUEST_WIDTH = $clog2(OUTPUTS),
  parameter int SELECT_WIDTH  = $clog2(INPUTS)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [INPUTS-1:0]                 routeReserveRequestValid,
  input  logic [INPUTS*REQUEST_WIDTH-1:0]   routeReserveRequest,
  input  logic [INPUTS-1:0]                 routeRelieve,
  output logic [INPUTS-1:0]                 routeReserveStatus,
  output logic [OUTPUTS*SELECT_WIDTH-1:0]   routeSelect,
  output logic [OUTPUTS-1:0]                outputBusy,
  output logic [INPUTS-1:0]                 PortReserved
);

  port_state_t             state      [INPUTS];
  port_state_t             state_next [INPUTS];
  logic [REQUEST_WIDTH-1:0] dest      [INPUTS];
  logic [REQUEST_WIDTH-1:0] dest_next [INPUTS];
  logic [SELECT_WIDTH-1:0] sel        [OUTPUTS];
  logic [SELECT_WIDTH-1:0] sel_next   [OUTPUTS];
  logic [INPUTS-1:0]       arb_req    [OUTPUTS];
  logic [INPUTS-1:0]       arb_grant  [OUTPUTS];
  logic [INPUTS-1:0]       granted;
  logic [OUTPUTS-1:0]      freed;
  logic [OUTPUTS-1:0]      busy_next;

  function automatic logic [SELECT_WIDTH-1:0] encode(input logic [INPUTS-1:0] onehot);
    logic [SELECT_WIDTH-1:0] idx;
    idx = {SELECT_WIDTH{1'b0}};
    for (int i = 0; i < INPUTS; i++) begin
      idx = idx | (onehot[i] ? SELECT_WIDTH'(i) : {SELECT_WIDTH{1'b0}});
    end
    return idx;
  endfunction

  // Busy outputs are masked here, so a freshly relieved output cannot be re-granted
  // until busy has actually cleared on the following edge.
  always_comb begin
    for (int o = 0; o < OUTPUTS; o++) begin
      freed[o] = 1'b0;
      for (int i = 0; i < INPUTS; i++) begin
        arb_req[o][i] = (state[i] == ST_REQUEST) && (dest[i] == REQUEST_WIDTH'(o))
                        && !outputBusy[o];
        freed[o] = freed[o] | ((state[i] == ST_RESERVED) && routeRelieve[i]
                               && (dest[i] == REQUEST_WIDTH'(o)));
      end
    end
  end

  for (genvar o = 0; o < OUTPUTS; o++) begin : g_arb
    rr_arbiter #(
      .WIDTH(INPUTS)
    ) u_arb (
      .clk  (clk),
      .rst  (rst),
      .req  (arb_req[o]),
      .grant(arb_grant[o])
    );
    assign routeSelect[o*SELECT_WIDTH +: SELECT_WIDTH] = sel[o];
  end

  // Each input is granted by at most one arbiter (the one for its latched output).
  always_comb begin
    granted = {INPUTS{1'b0}};
    for (int o = 0; o < OUTPUTS; o++) begin
      granted = granted | arb_grant[o];
    end
  end

  always_comb begin
    for (int o = 0; o < OUTPUTS; o++) begin
      busy_next[o] = (|arb_grant[o]) | (outputBusy[o] & ~freed[o]);
      sel_next[o]  = (|arb_grant[o]) ? encode(arb_grant[o]) : sel[o];
    end
  end

  // Per-input path FSM next state; out-of-range destinations are dropped silently.
  always_comb begin
    logic [REQUEST_WIDTH-1:0] field;
    field = {REQUEST_WIDTH{1'b0}};
    for (int i = 0; i < INPUTS; i++) begin
      field         = routeReserveRequest[i*REQUEST_WIDTH +: REQUEST_WIDTH];
      state_next[i] = state[i];
      dest_next[i]  = dest[i];
      case (state[i])
        ST_UNROUTED: begin
          if (routeReserveRequestValid[i] && (int'(field) < OUTPUTS)) begin
            state_next[i] = ST_REQUEST;
            dest_next[i]  = field;
          end else begin
            state_next[i] = ST_UNROUTED;
          end
        end
        ST_REQUEST:  state_next[i] = granted[i] ? ST_GRANTED : ST_REQUEST;
        ST_GRANTED:  state_next[i] = ST_RESERVED;
        ST_RESERVED: state_next[i] = routeRelieve[i] ? ST_UNROUTED : ST_RESERVED;
        default:     state_next[i] = ST_UNROUTED;
      endcase
    end
  end

  // State, ownership and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < INPUTS; i++) begin
        state[i] <= ST_UNROUTED;
        dest[i]  <= {REQUEST_WIDTH{1'b0}};
      end
      for (int o = 0; o < OUTPUTS; o++) begin
        sel[o] <= {SELECT_WIDTH{1'b0}};
      end
      outputBusy         <= {OUTPUTS{1'b0}};
      routeReserveStatus <= {INPUTS{1'b0}};
      PortReserved       <= {INPUTS{1'b0}};
    end else begin
      for (int i = 0; i < INPUTS; i++) begin
        state[i]              <= state_next[i];
        dest[i]               <= dest_next[i];
        routeReserveStatus[i] <= (state_next[i] == ST_GRANTED);
        PortReserved[i]       <= (state_next[i] == ST_RESERVED);
      end
      for (int o = 0; o < OUTPUTS; o++) begin
        sel[o] <= sel_next[o];
      end
      outputBusy <= busy_next;
    end
  end

endmodule
